// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle MIPS controller and its shared-memory datapath.
// Latency: none (pure wiring bundle).
// Backpressure: mem_ready from the memory side stalls the controller in its memory states.
//
// Ports / signals:
//   datapath -> controller : op[5:0], funct[5:0], zero, mem_ready
//   controller -> datapath : mem_req, iord, memwrite, irwrite, pcen, pcsrc[1:0],
//                            alusrca, alusrcb[1:0], alucontrol[2:0], regdst,
//                            memtoreg, regwrite, illegal, mem_err, state_o[3:0]
// Modports: master = controller side, slave = datapath / memory side.
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       mem_req;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       illegal;
  logic       mem_err;
  logic [3:0] state_o;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
           alucontrol, regdst, memtoreg, regwrite, illegal, mem_err, state_o
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
           alucontrol, regdst, memtoreg, regwrite, illegal, mem_err, state_o
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM sequencing a shared ALU / single memory port datapath.
// Latency: lw 5 cycles, sw/R-type/addi 4, beq/j(/bne) 3, plus memory wait cycles.
// Backpressure: FETCH/MEMRD/MEMWR hold until mem_ready; abort to FETCH after MEM_TIMEOUT.
//
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset (FETCH, counters and sticky flags cleared)
//   bus      : mc_controller_if.master -- instruction fields, zero flag and mem_ready in;
//              datapath enables/selects, sticky illegal/mem_err and state_o out
// Parameters:
//   MEM_TIMEOUT : wait cycles allowed in one memory state (1 .. 2^TO_W-1)
//   TO_W        : width of the wait counter
// Configuration macro:
//   MC_BNE_EN   : when defined, op 000101 (bne) is decoded and executed in BNEEX;
//                 when undefined, bne is treated as an illegal opcode.
module mc_controller #(
  parameter int MEM_TIMEOUT = 200,
  parameter int TO_W        = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control encodings
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Select encodings
  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMMSH   = 2'b11;

  // Last counter value before the wait is declared dead.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] wait_q;
  logic            illegal_q;
  logic            mem_err_q;

  logic            set_illegal;
  logic            mem_state;
  logic            timeout;

  logic            pcwrite;
  logic            branch;
  logic            branch_cond;

  logic            mem_req;
  logic            iord;
  logic            memwrite;
  logic            irwrite;
  logic [1:0]      pcsrc;
  logic            alusrca;
  logic [1:0]      alusrcb;
  logic [2:0]      alucontrol;
  logic            regdst;
  logic            memtoreg;
  logic            regwrite;

  // States that wait on the memory handshake and therefore run the timeout counter.
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // mem_ready on the final allowed cycle takes priority over the abort.
  assign timeout   = mem_state && !bus.mem_ready && (wait_q == TO_LAST);

  //--------------------------------------------------------------------------
  // State register, wait counter, sticky flags
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_q <= '0;
    end else if (timeout || (state_d != state_q)) begin
      // A FETCH timeout re-enters FETCH, so it must clear explicitly.
      wait_q <= '0;
    end else if (mem_state && !bus.mem_ready) begin
      wait_q <= wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      if (set_illegal) illegal_q <= 1'b1;
      if (timeout)     mem_err_q <= 1'b1;
    end
  end

  //--------------------------------------------------------------------------
  // Next state and control outputs
  //--------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    pcwrite     = 1'b0;
    branch      = 1'b0;
    branch_cond = 1'b0;
    mem_req     = 1'b0;
    iord        = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    pcsrc       = PCSRC_ALURES;
    alusrca     = 1'b0;
    alusrcb     = SRCB_REGB;
    alucontrol  = ALU_ADD;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 computed on the ALU while the instruction is read.
        mem_req = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = bus.mem_ready;
        pcwrite = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        // Branch target precomputed into ALUOut for a possible beq/bne.
        alusrcb = SRCB_IMMSH;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default: begin
            set_illegal = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEMWR: begin
        // Write strobe stays up until the memory accepts it.
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end

      S_RTYPEEX: begin
        alusrca = 1'b1;
        case (bus.funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: begin
            // Unknown funct still completes as an add so the pipeline of steps stays uniform.
            alucontrol  = ALU_ADD;
            set_illegal = 1'b1;
          end
        endcase
        state_d = S_RTYPEWB;
      end

      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_BEQEX: begin
        alusrca     = 1'b1;
        alucontrol  = ALU_SUB;
        pcsrc       = PCSRC_ALUOUT;
        branch      = 1'b1;
        branch_cond = bus.zero;
        state_d     = S_FETCH;
      end

      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = S_ADDIWB;
      end

      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_JEX: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end

`ifdef MC_BNE_EN
      S_BNEEX: begin
        alusrca     = 1'b1;
        alucontrol  = ALU_SUB;
        pcsrc       = PCSRC_ALUOUT;
        branch      = 1'b1;
        branch_cond = ~bus.zero;
        state_d     = S_FETCH;
      end
`endif

      default: state_d = S_FETCH;
    endcase

    // Abort a stalled memory access. mem_ready is low here, so no enable was raised.
    if (timeout) state_d = S_FETCH;
  end

  //--------------------------------------------------------------------------
  // Output drive
  //--------------------------------------------------------------------------
  assign bus.mem_req    = mem_req;
  assign bus.iord       = iord;
  assign bus.memwrite   = memwrite;
  assign bus.irwrite    = irwrite;
  assign bus.pcen       = pcwrite | (branch & branch_cond);
  assign bus.pcsrc      = pcsrc;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.alucontrol = alucontrol;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.regwrite   = regwrite;
  assign bus.illegal    = illegal_q;
  assign bus.mem_err    = mem_err_q;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: the driver applies one directed input vector per
// cycle and queues the expected state/control word; a negedge monitor pops and compares.
module tb_mc_controller;

  localparam int TO = 200;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_ADI = 6'b001000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_BAD = 6'b111111;

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4, MWR = 4'd5;
  localparam logic [3:0] RX = 4'd6, RW = 4'd7, BQ = 4'd8, AX = 4'd9, AW = 4'd10, JX = 4'd11;
  localparam logic [3:0] BN = 4'd12;

  localparam logic [2:0] A_ADD = 3'b010, A_SUB = 3'b110;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal;
    logic       mem_err;
  } ctrl_t;

  typedef struct {
    string      name;
    logic [3:0] st;
    ctrl_t      ctrl;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  mc_controller_if bus();

  mc_controller #(.MEM_TIMEOUT(TO), .TO_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Spec table of the input-independent outputs of each state.
  function automatic ctrl_t base(input logic [3:0] st);
    ctrl_t c;
    c = '0;
    c.alucontrol = A_ADD;
    case (st)
      F:   begin c.mem_req = 1'b1; c.alusrcb = 2'b01; end
      D:   c.alusrcb = 2'b11;
      MA:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MR:  begin c.mem_req = 1'b1; c.iord = 1'b1; end
      MWB: begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      MWR: begin c.mem_req = 1'b1; c.iord = 1'b1; c.memwrite = 1'b1; end
      RX:  c.alusrca = 1'b1;
      RW:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      BQ, BN: begin c.alusrca = 1'b1; c.alucontrol = A_SUB; c.pcsrc = 2'b01; end
      AX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      AW:  c.regwrite = 1'b1;
      JX:  c.pcsrc = 2'b10;
      default: ;
    endcase
    return c;
  endfunction

  // One cycle: drive inputs just after the edge and queue what the DUT must show.
  task automatic step(input string nm, input logic rn, input logic mr, input logic z,
                      input logic [5:0] op, input logic [5:0] fn, input logic [3:0] st,
                      input logic pcen, input logic irw, input logic [2:0] alu,
                      input logic ill, input logic err);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n       = rn;
    bus.mem_ready = mr;
    bus.zero      = z;
    bus.op        = op;
    bus.funct     = fn;
    e.name        = nm;
    e.st          = st;
    e.ctrl        = base(st);
    e.ctrl.pcen    = pcen;
    e.ctrl.irwrite = irw;
    if (st == RX) e.ctrl.alucontrol = alu;
    e.ctrl.illegal = ill;
    e.ctrl.mem_err = err;
    sb_q.push_back(e);
  endtask

  // Monitor: the controller presents a control word every cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t  e;
      ctrl_t act;
      e   = sb_q.pop_front();
      act = '{bus.mem_req, bus.iord, bus.memwrite, bus.irwrite, bus.pcen, bus.pcsrc,
              bus.alusrca, bus.alusrcb, bus.alucontrol, bus.regdst, bus.memtoreg,
              bus.regwrite, bus.illegal, bus.mem_err};
      checks++;
      if ((bus.state_o !== e.st) || (act !== e.ctrl)) begin
        errors++;
        $display("FAIL %s: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 e.name, bus.state_o, act, e.st, e.ctrl);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;
    bus.op        = OP_BAD;
    bus.funct     = 6'b0;
    repeat (2) @(posedge clk);

    // Reset state, then FETCH stall of 3 cycles and a single fetch pulse.
    step("reset_fetch",  0, 0, 0, OP_BAD, 0, F,  0, 0, A_ADD, 0, 0);
    step("fetch_wait1",  1, 0, 0, OP_BAD, 0, F,  0, 0, A_ADD, 0, 0);
    step("fetch_wait2",  1, 0, 0, OP_BAD, 0, F,  0, 0, A_ADD, 0, 0);
    step("fetch_wait3",  1, 0, 0, OP_BAD, 0, F,  0, 0, A_ADD, 0, 0);
    step("fetch_go",     1, 1, 0, OP_BAD, 0, F,  1, 1, A_ADD, 0, 0);
    step("decode_bad",   1, 1, 0, OP_BAD, 0, D,  0, 0, A_ADD, 0, 0);
    step("ill_fetch",    1, 1, 0, OP_LW,  0, F,  1, 1, A_ADD, 1, 0);

    // lw with mem_ready high: 0,1,2,3,4,0.
    step("lw_dec",       1, 1, 0, OP_LW,  0, D,  0, 0, A_ADD, 1, 0);
    step("lw_madr",      1, 1, 0, OP_LW,  0, MA, 0, 0, A_ADD, 1, 0);
    step("lw_memrd",     1, 1, 0, OP_LW,  0, MR, 0, 0, A_ADD, 1, 0);
    step("lw_memwb",     1, 1, 0, OP_LW,  0, MWB,0, 0, A_ADD, 1, 0);
    step("lw_fetch",     1, 1, 0, OP_LW,  0, F,  1, 1, A_ADD, 1, 0);

    // Second lw stalled in MEMRD, then reset in the middle of the cycle.
    step("lw2_dec",      1, 1, 0, OP_LW,  0, D,  0, 0, A_ADD, 1, 0);
    step("lw2_madr",     1, 1, 0, OP_LW,  0, MA, 0, 0, A_ADD, 1, 0);
    step("lw2_memrd",    1, 0, 0, OP_LW,  0, MR, 0, 0, A_ADD, 1, 0);
    step("rst_mid_rd",   0, 0, 0, OP_LW,  0, F,  0, 0, A_ADD, 0, 0);

    // sw with one cycle of write backpressure.
    step("sw_fetch",     1, 1, 0, OP_SW,  0, F,  1, 1, A_ADD, 0, 0);
    step("sw_dec",       1, 1, 0, OP_SW,  0, D,  0, 0, A_ADD, 0, 0);
    step("sw_madr",      1, 1, 0, OP_SW,  0, MA, 0, 0, A_ADD, 0, 0);
    step("sw_wr_hold",   1, 0, 0, OP_SW,  0, MWR,0, 0, A_ADD, 0, 0);
    step("sw_wr_go",     1, 1, 0, OP_SW,  0, MWR,0, 0, A_ADD, 0, 0);

    // R-type sub, then R-type with an undecodable funct.
    step("rt_fetch",     1, 1, 0, OP_R, FN_SUB, F,  1, 1, A_ADD, 0, 0);
    step("rt_dec",       1, 1, 0, OP_R, FN_SUB, D,  0, 0, A_ADD, 0, 0);
    step("rt_ex_sub",    1, 1, 0, OP_R, FN_SUB, RX, 0, 0, A_SUB, 0, 0);
    step("rt_wb",        1, 1, 0, OP_R, FN_SUB, RW, 0, 0, A_ADD, 0, 0);
    step("rt2_fetch",    1, 1, 0, OP_R, FN_BAD, F,  1, 1, A_ADD, 0, 0);
    step("rt2_dec",      1, 1, 0, OP_R, FN_BAD, D,  0, 0, A_ADD, 0, 0);
    step("rt2_ex_bad",   1, 1, 0, OP_R, FN_BAD, RX, 0, 0, A_ADD, 0, 0);
    step("rt2_wb",       1, 1, 0, OP_R, FN_BAD, RW, 0, 0, A_ADD, 1, 0);

    // beq taken / not taken, j, addi.
    step("beq_fetch",    1, 1, 1, OP_BEQ, 0, F,  1, 1, A_ADD, 1, 0);
    step("beq_dec",      1, 1, 1, OP_BEQ, 0, D,  0, 0, A_ADD, 1, 0);
    step("beq_taken",    1, 1, 1, OP_BEQ, 0, BQ, 1, 0, A_ADD, 1, 0);
    step("beq2_fetch",   1, 1, 0, OP_BEQ, 0, F,  1, 1, A_ADD, 1, 0);
    step("beq2_dec",     1, 1, 0, OP_BEQ, 0, D,  0, 0, A_ADD, 1, 0);
    step("beq_not",      1, 1, 0, OP_BEQ, 0, BQ, 0, 0, A_ADD, 1, 0);
    step("j_fetch",      1, 1, 0, OP_J,   0, F,  1, 1, A_ADD, 1, 0);
    step("j_dec",        1, 1, 0, OP_J,   0, D,  0, 0, A_ADD, 1, 0);
    step("j_ex",         1, 1, 0, OP_J,   0, JX, 1, 0, A_ADD, 1, 0);
    step("addi_fetch",   1, 1, 0, OP_ADI, 0, F,  1, 1, A_ADD, 1, 0);
    step("addi_dec",     1, 1, 0, OP_ADI, 0, D,  0, 0, A_ADD, 1, 0);
    step("addi_ex",      1, 1, 0, OP_ADI, 0, AX, 0, 0, A_ADD, 1, 0);
    step("addi_wb",      1, 1, 0, OP_ADI, 0, AW, 0, 0, A_ADD, 1, 0);

    // bne with zero=0 after clearing the sticky flag.
    step("bne_rst",      0, 0, 0, OP_BNE, 0, F,  0, 0, A_ADD, 0, 0);
    step("bne_fetch",    1, 1, 0, OP_BNE, 0, F,  1, 1, A_ADD, 0, 0);
    step("bne_dec",      1, 1, 0, OP_BNE, 0, D,  0, 0, A_ADD, 0, 0);
`ifdef MC_BNE_EN
    step("bne_ex",       1, 1, 0, OP_BNE, 0, BN, 1, 0, A_ADD, 0, 0);
    step("bne_done",     1, 1, 0, OP_BNE, 0, F,  1, 1, A_ADD, 0, 0);
`else
    step("bne_illegal",  1, 1, 0, OP_BNE, 0, F,  1, 1, A_ADD, 1, 0);
`endif

    // Timeout boundary: mem_ready arriving on the last allowed cycle wins.
    step("to_rst",       0, 0, 0, OP_J, 0, F, 0, 0, A_ADD, 0, 0);
    for (int i = 0; i < TO - 1; i++)
      step("to_wait_a",  1, 0, 0, OP_J, 0, F, 0, 0, A_ADD, 0, 0);
    step("to_last_rdy",  1, 1, 0, OP_J, 0, F,  1, 1, A_ADD, 0, 0);
    step("to_rdy_dec",   1, 1, 0, OP_J, 0, D,  0, 0, A_ADD, 0, 0);
    step("to_j_ex",      1, 1, 0, OP_J, 0, JX, 1, 0, A_ADD, 0, 0);

    // Full timeout: MEM_TIMEOUT idle cycles in FETCH, then mem_err and a clean FETCH.
    for (int i = 0; i < TO; i++)
      step("to_wait_b",  1, 0, 0, OP_J, 0, F, 0, 0, A_ADD, 0, 0);
    step("to_err",       1, 0, 0, OP_J, 0, F,  0, 0, A_ADD, 0, 1);
    step("to_err_fetch", 1, 1, 0, OP_J, 0, F,  1, 1, A_ADD, 0, 1);
    step("to_err_dec",   1, 1, 0, OP_J, 0, D,  0, 0, A_ADD, 0, 1);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
